dmem_arbiter: RTL and testbench

//  Shares the single data_memory between the core load/store port and a debug/loader port (valid/ready).

---
 rtl/dmem_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one data_memory between the core load/store port and a
// debug/loader port. Optional round-robin tie-break enabled by defining DMEM_ARB_RR_EN.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_rd,
    input  logic              c_wr,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_stall,
    input  logic              d_valid,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_rd,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } own_t;

    // Remaining WAIT cycles after ISSUE; zero means the read data is sampled straight out of ISSUE.
    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 32'sd1);

    state_t            state_r;
    state_t            state_s;
    own_t              own_r;
    logic              we_r;
    logic [2:0]        cnt_r;
    logic              m_rd_r;
    logic              m_wr_r;
    logic [ADDR_W-1:0] m_addr_r;
    logic [DATA_W-1:0] m_wdata_r;
    logic [DATA_W-1:0] c_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;
    logic              d_rvalid_r;

    logic              c_req_s;
    logic              core_pri_s;
    logic              grant_core_s;
    logic              grant_dbg_s;
    logic              grant_s;
    logic              capture_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

`ifdef DMEM_ARB_RR_EN
    own_t              last_grant_r;
`endif

    // Arbitration between core and debug requests and selection of the winning request fields.
    always_comb begin
        c_req_s = c_rd | c_wr;
`ifdef DMEM_ARB_RR_EN
        core_pri_s = (last_grant_r == OWN_DBG);
`else
        core_pri_s = 1'b1;
`endif
        grant_core_s = c_req_s & (~d_valid | core_pri_s);
        grant_dbg_s  = d_valid & ~grant_core_s;
        grant_s      = (state_r == IDLE) & (grant_core_s | grant_dbg_s);
        if (grant_dbg_s) begin
            sel_we_s    = d_we;
            sel_addr_s  = d_addr;
            sel_wdata_s = d_wdata;
        end else begin
            sel_we_s    = c_wr;
            sel_addr_s  = c_addr;
            sel_wdata_s = c_wdata;
        end
    end

    // Next-state logic; capture_s marks the cycle whose m_rdata is the read result.
    always_comb begin
        state_s   = state_r;
        capture_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (we_r) begin
                    state_s = DONE;
                end else if (LAT_M1 == 3'd0) begin
                    state_s   = DONE;
                    capture_s = 1'b1;
                end else begin
                    state_s = WAIT;
                end
            end
            WAIT: begin
                if (cnt_r == 3'd1) begin
                    state_s   = DONE;
                    capture_s = 1'b1;
                end else begin
                    state_s = WAIT;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant latching, memory strobes, latency counter and read-data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            own_r      <= OWN_CORE;
            we_r       <= 1'b0;
            cnt_r      <= 3'd0;
            m_rd_r     <= 1'b0;
            m_wr_r     <= 1'b0;
            m_addr_r   <= '0;
            m_wdata_r  <= '0;
            c_rdata_r  <= '0;
            d_rdata_r  <= '0;
            d_rvalid_r <= 1'b0;
        end else begin
            m_rd_r     <= 1'b0;
            m_wr_r     <= 1'b0;
            d_rvalid_r <= 1'b0;
            if (grant_s) begin
                own_r     <= grant_dbg_s ? OWN_DBG : OWN_CORE;
                we_r      <= sel_we_s;
                m_addr_r  <= sel_addr_s;
                m_wdata_r <= sel_wdata_s;
                m_rd_r    <= ~sel_we_s;
                m_wr_r    <= sel_we_s;
            end
            if (state_r == ISSUE) begin
                cnt_r <= LAT_M1;
            end else if (state_r == WAIT) begin
                cnt_r <= cnt_r - 3'd1;
            end
            // A core that withdrew its load mid-access gets no result.
            if (capture_s) begin
                if (own_r == OWN_DBG) begin
                    d_rdata_r  <= m_rdata;
                    d_rvalid_r <= 1'b1;
                end else if (c_rd) begin
                    c_rdata_r <= m_rdata;
                end
            end
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Grant history for the round-robin tie-break.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= OWN_CORE;
        end else if (grant_s) begin
            last_grant_r <= grant_dbg_s ? OWN_DBG : OWN_CORE;
        end
    end
`endif

    // Handshake outputs are combinational so the core stalls in its very first request cycle.
    always_comb begin
        c_stall = ~rst & c_req_s & ~((state_r == DONE) & (own_r == OWN_CORE));
        d_ready = ~rst & grant_s & grant_dbg_s;
    end

    assign c_rdata  = c_rdata_r;
    assign d_rdata  = d_rdata_r;
    assign d_rvalid = d_rvalid_r;
    assign m_rd     = m_rd_r;
    assign m_wr     = m_wr_r;
    assign m_addr   = m_addr_r;
    assign m_wdata  = m_wdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed core/debug traffic against a latency-accurate
// memory model; expected memory ops, completions and debug responses are queued and popped by a monitor.
module tb_dmem_arbiter;

    localparam int LAT = 3;

    typedef struct {
        logic        flag;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        c_rd;
    logic        c_wr;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [31:0] c_rdata;
    logic        c_stall;
    logic        d_valid;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_rd;
    logic        m_wr;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    int   cyc;
    int   total;
    int   bad;
    logic chk_zero;
    logic end_req;
    logic [31:0] last_core_rd;

    exp_t mem_q[$];
    exp_t core_q[$];
    exp_t dbg_q[$];
    exp_t acc_q[$];

    logic [31:0] mem   [0:255];
    logic [31:0] dpipe [0:7];
    logic [7:0]  vpipe;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .c_rd(c_rd), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_stall(c_stall),
        .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: writes on the strobe edge; read data is presented only in the cycle the arbiter samples it.
    always @(posedge clk) begin
        if (m_wr) mem[m_addr[7:0]] <= m_wdata;
        vpipe    <= {vpipe[6:0], m_rd};
        dpipe[0] <= mem[m_addr[7:0]];
        for (int i = 1; i < 8; i++) dpipe[i] <= dpipe[i-1];
    end

    generate
        if (LAT == 1) begin : g_lat1
            assign m_rdata = m_rd ? mem[m_addr[7:0]] : 32'hBAD0_0BAD;
        end else begin : g_latn
            assign m_rdata = vpipe[LAT-2] ? dpipe[LAT-2] : 32'hBAD0_0BAD;
        end
    endgenerate

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(inout exp_t q[$], input logic f, input logic [31:0] a,
                        input logic [31:0] d, input int c);
        exp_t e;
        e.flag = f; e.addr = a; e.data = d; e.cyc = c;
        q.push_back(e);
    endtask

    // Monitor: pops expectations whenever the DUT presents an event and checks invariants.
    always @(negedge clk) begin
        exp_t e;
        if (chk_zero) begin
            chk("rst_ctrl", 64'({c_stall, d_ready, d_rvalid, m_rd, m_wr}), 64'd0);
            chk("rst_m_addr", 64'(m_addr), 64'd0);
            chk("rst_m_wdata", 64'(m_wdata), 64'd0);
            chk("rst_c_rdata", 64'(c_rdata), 64'd0);
            chk("rst_d_rdata", 64'(d_rdata), 64'd0);
        end
        if (rst) begin
            last_core_rd = 32'd0;
        end else begin
            if (m_rd || m_wr) begin
                total++;
                if (mem_q.size() == 0) begin
                    bad++;
                    $display("FAIL mem_unexpected: op rd=%0b wr=%0b addr %0h at cycle %0d", m_rd, m_wr, m_addr, cyc);
                end else begin
                    e = mem_q.pop_front();
                    chk("mem_cyc", 64'(cyc), 64'(e.cyc));
                    chk("mem_op", 64'({m_rd, m_wr}), 64'({~e.flag, e.flag}));
                    chk("mem_addr", 64'(m_addr), 64'(e.addr));
                    if (e.flag) chk("mem_wdata", 64'(m_wdata), 64'(e.data));
                end
            end
            if ((c_rd || c_wr) && !c_stall) begin
                total++;
                if (core_q.size() == 0) begin
                    bad++;
                    $display("FAIL core_unexpected: completion at cycle %0d", cyc);
                end else begin
                    e = core_q.pop_front();
                    chk("core_done_cyc", 64'(cyc), 64'(e.cyc));
                    if (e.flag) begin
                        chk("core_rdata", 64'(c_rdata), 64'(e.data));
                        last_core_rd = e.data;
                    end
                end
            end else begin
                chk("c_rdata_hold", 64'(c_rdata), 64'(last_core_rd));
            end
            if (d_rvalid) begin
                total++;
                if (dbg_q.size() == 0) begin
                    bad++;
                    $display("FAIL dbg_unexpected: d_rvalid at cycle %0d", cyc);
                end else begin
                    e = dbg_q.pop_front();
                    chk("dbg_rvalid_cyc", 64'(cyc), 64'(e.cyc));
                    chk("dbg_rdata", 64'(d_rdata), 64'(e.data));
                end
            end
            if (d_valid && d_ready) begin
                total++;
                if (acc_q.size() == 0) begin
                    bad++;
                    $display("FAIL dbg_accept_unexpected: d_ready at cycle %0d", cyc);
                end else begin
                    e = acc_q.pop_front();
                    chk("dbg_accept_cyc", 64'(cyc), 64'(e.cyc));
                end
            end
            if (!(c_rd || c_wr)) chk("stall_no_req", 64'(c_stall), 64'd0);
            if (!d_valid) chk("ready_no_valid", 64'(d_ready), 64'd0);
        end
        if (end_req) begin
            chk("mem_q_left", 64'(mem_q.size()), 64'd0);
            chk("core_q_left", 64'(core_q.size()), 64'd0);
            chk("dbg_q_left", 64'(dbg_q.size()), 64'd0);
            chk("acc_q_left", 64'(acc_q.size()), 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_core();
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!c_stall) break;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        total = 0; bad = 0; chk_zero = 1'b0; end_req = 1'b0;
        rst = 1'b1;
        c_rd = 1'b0; c_wr = 1'b0; c_addr = 32'd0; c_wdata = 32'd0;
        d_valid = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hDEAD_BEEF;
        mem[8'h40] = 32'hCAFE_F00D;
        mem[8'h50] = 32'h5555_AAAA;

        repeat (2) tick();
        chk_zero = 1'b1;
        tick();
        chk_zero = 1'b0;
        rst = 1'b0;
        tick();

        // Core load from idle.
        t = cyc; c_rd = 1'b1; c_addr = 32'h10;
        push(mem_q, 1'b0, 32'h10, 32'h0, t + 1);
        push(core_q, 1'b1, 32'h10, 32'hDEAD_BEEF, t + LAT + 1);
        wait_core(); tick(); c_rd = 1'b0; tick();

        // Core store followed immediately by a load of the same word.
        t = cyc; c_wr = 1'b1; c_addr = 32'h20; c_wdata = 32'h1234;
        push(mem_q, 1'b1, 32'h20, 32'h1234, t + 1);
        push(core_q, 1'b0, 32'h20, 32'h0, t + 2);
        wait_core(); tick();
        c_wr = 1'b0; c_rd = 1'b1;
        t = cyc;
        push(mem_q, 1'b0, 32'h20, 32'h0, t + 1);
        push(core_q, 1'b1, 32'h20, 32'h1234, t + LAT + 1);
        wait_core(); tick(); c_rd = 1'b0; tick();

        // Debug read with the core idle.
        t = cyc; d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        push(acc_q, 1'b0, 32'h40, 32'h0, t);
        push(mem_q, 1'b0, 32'h40, 32'h0, t + 1);
        push(dbg_q, 1'b0, 32'h40, 32'hCAFE_F00D, t + LAT + 1);
        tick(); d_valid = 1'b0;
        repeat (5) tick();

        // Debug write granted, core load of the same word arrives one cycle later.
        t = cyc; d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h50; d_wdata = 32'h77;
        push(acc_q, 1'b1, 32'h50, 32'h0, t);
        push(mem_q, 1'b1, 32'h50, 32'h77, t + 1);
        push(mem_q, 1'b0, 32'h50, 32'h0, t + 4);
        push(core_q, 1'b1, 32'h50, 32'h77, t + LAT + 4);
        tick();
        d_valid = 1'b0; d_we = 1'b0; c_rd = 1'b1; c_addr = 32'h50;
        wait_core(); tick(); c_rd = 1'b0; tick();

        // Core and debug both requesting continuously for 15 cycles.
        t = cyc; c_rd = 1'b1; c_addr = 32'h10; d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h40;
`ifdef DMEM_ARB_RR_EN
        push(acc_q, 1'b0, 32'h40, 32'h0, t);
        push(mem_q, 1'b0, 32'h40, 32'h0, t + 1);
        push(dbg_q, 1'b0, 32'h40, 32'hCAFE_F00D, t + LAT + 1);
        push(mem_q, 1'b0, 32'h10, 32'h0, t + LAT + 3);
        push(core_q, 1'b1, 32'h10, 32'hDEAD_BEEF, t + 2 * LAT + 3);
        push(acc_q, 1'b0, 32'h40, 32'h0, t + 2 * LAT + 4);
        push(mem_q, 1'b0, 32'h40, 32'h0, t + 2 * LAT + 5);
        push(dbg_q, 1'b0, 32'h40, 32'hCAFE_F00D, t + 3 * LAT + 5);
`else
        for (int k = 0; k < 3; k++) begin
            push(mem_q, 1'b0, 32'h10, 32'h0, t + 1 + k * (LAT + 2));
            push(core_q, 1'b1, 32'h10, 32'hDEAD_BEEF, t + LAT + 1 + k * (LAT + 2));
        end
`endif
        repeat (15) tick();
        c_rd = 1'b0; d_valid = 1'b0;
        repeat (2) tick();

        // Reset pulsed while a debug read sits in WAIT.
        t = cyc; d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        push(acc_q, 1'b0, 32'h40, 32'h0, t);
        push(mem_q, 1'b0, 32'h40, 32'h0, t + 1);
        tick(); d_valid = 1'b0;
        tick();
        rst = 1'b1; chk_zero = 1'b1;
        tick();
        chk_zero = 1'b0;
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Fresh core load after reset.
        t = cyc; c_rd = 1'b1; c_addr = 32'h10;
        push(mem_q, 1'b0, 32'h10, 32'h0, t + 1);
        push(core_q, 1'b1, 32'h10, 32'hDEAD_BEEF, t + LAT + 1);
        wait_core(); tick(); c_rd = 1'b0;
        repeat (3) tick();

        end_req = 1'b1;
        @(negedge clk);
        #1;
        end_req = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
